line_window_gen: RTL and testbench
==================================

Name: line_window_gen

Overview:
- Parametrised 3x3 sliding-window generator.
- Accepts a raster pixel stream from the memory controller through a valid/ready handshake and stores it in three circular line buffers.
- Emits one zero-padded 3x3 window per pixel of the frame to the filter core, using a valid/ready handshake on the output.
- Generalises the fixed 540-column, 8-bit, 3-row preprocess stage: configurable width and resolution, frame-level rows, border padding and output backpressure.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_COLS, 540, pixels per row; must be at least 2.
- IMG_ROWS, 360, rows per frame; must be at least 2.
- COL_W, 10, column counter width; 2^COL_W must be at least IMG_COLS.
- ROW_W, 9, row counter width; 2^ROW_W must be at least IMG_ROWS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle frame start request; honoured only in IDLE.
- pix_valid_i  in  1  input pixel valid.
- pix_data_i  in  DATA_W  input pixel, raster order.
- pix_ready_o  out  1  block accepts a pixel this cycle.
- win_valid_o  out  1  window valid.
- win_ready_i  in  1  core accepts the window.
- win_o  out  9*DATA_W  window; element (i,j) is at bits [(3*i+j)*DATA_W +: DATA_W]; i=0 is the row above the centre, j=0 is the column left of the centre.
- win_row_o  out  ROW_W  centre row of the current window.
- win_col_o  out  COL_W  centre column of the current window.
- busy_o  out  1  high in any state other than IDLE.
- frame_done_o  out  1  one-cycle pulse when the last window of the frame is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; all counters go to 0.
  - pix_ready_o, win_valid_o, busy_o and frame_done_o go to 0; win_o, win_row_o and win_col_o go to 0.
  - Line memories are not cleared; padding is produced by masking, never by memory contents.
  - Reset mid-frame abandons the frame silently.
- Storage: row r is written to line (r mod 3). The write column wraps to 0 after IMG_COLS-1.
- States:
  - IDLE -> FILL on start_i. wr_row=0, wr_col=0.
  - FILL: pix_ready_o=1. Each accepted pixel (valid and ready) is written at (wr_row mod 3, wr_col), then wr_col increments.
    - On acceptance of column IMG_COLS-1: wr_col goes to 0 and wr_row increments.
    - If the completed row is 0, stay in FILL.
    - Otherwise go to EMIT with centre row = completed row - 1.
  - EMIT: pix_ready_o=0. Windows are produced for centre columns 0..IMG_COLS-1 of the centre row.
    - After the window at column IMG_COLS-1 is accepted:
      - If the completed row was IMG_ROWS-1, go to LAST with centre row IMG_ROWS-1.
      - Otherwise go to FILL.
  - LAST: same as EMIT, with bottom padding. After its final window is accepted, go to IDLE and pulse frame_done_o in the following cycle.
- Window content for centre (r,c):
  - Element (i,j) = pixel (r-1+i, c-1+j).
  - Value is zero when that row is < 0 or > IMG_ROWS-1, or that column is < 0 or > IMG_COLS-1.
- Output registers:
  - win_valid_o rises one clk after entry to EMIT or LAST (one-cycle read latency).
  - While win_valid_o=1 and win_ready_i=0, win_o, win_row_o and win_col_o hold stable.
  - On handshake, the next window is presented in the following cycle, giving back-to-back throughput of 1 window per clk with win_ready_i held high.
  - win_valid_o drops in the cycle after the last window of a row is accepted.
- pix_valid_i is ignored outside FILL. start_i is ignored outside IDLE.
- Total accepted pixels per frame: IMG_COLS*IMG_ROWS. Total windows per frame: the same.

Test Plan:
Common setup: IMG_COLS=4, IMG_ROWS=3; pixel (r,c) = 16*r+c+1, so row0 = 1..4, row1 = 17..20, row2 = 33..36. Windows below are listed row by row (i=0,1,2).
1. Full frame, win_ready_i=1 -> 12 windows in raster order.
   - (0,0) = {0,0,0 / 0,1,2 / 0,17,18}.
   - (1,1) = {1,2,3 / 17,18,19 / 33,34,35}.
   - (2,3) = {19,20,0 / 35,36,0 / 0,0,0}.
   - frame_done_o pulses exactly once; busy_o then drops.
2. Input gaps (pix_valid_i toggled every other cycle) -> identical windows. pix_ready_o=0 during every EMIT/LAST.
3. Backpressure: win_ready_i low for 5 cycles at window (1,2) -> win_o = {2,3,4 / 18,19,20 / 34,35,36} held stable, win_col_o=2 throughout, no window skipped or duplicated.
4. Reset asserted mid-EMIT of row 1, then a new start_i -> all outputs 0 after reset; the second frame's windows are correct and contain no stale data in padding.
5. start_i pulsed during FILL, and pix_valid_i high during EMIT -> both ignored; pixel count and window count remain 12 each.
6. Two consecutive frames with IMG_COLS=540, IMG_ROWS=4 -> 2160 windows per frame; column wrap at 539 is correct; frame_done_o pulses twice.

Source files
------------

// File: rtl/line_window_gen.sv
// line_window_gen: 3x3 sliding-window generator over a raster pixel stream.
// Pixels arrive through a valid/ready handshake and are stored in three circular
// line buffers (row r lives in line r mod 3). Once the row below a centre row is
// stored, one zero-padded 3x3 window per centre column is emitted through a
// second valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   start_i           one-cycle frame start (honoured only in IDLE)
//   pix_valid_i/pix_data_i/pix_ready_o   input pixel stream, raster order
//   win_valid_o/win_ready_i/win_o        window stream; element (i,j) at
//                                        bits [(3*i+j)*DATA_W +: DATA_W]
//   win_row_o/win_col_o                  centre coordinates of win_o
//   busy_o            high outside IDLE
//   frame_done_o      one-cycle pulse after the last window is accepted
module line_window_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_COLS = 540,
  parameter int unsigned IMG_ROWS = 360,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                pix_valid_i,
  input  logic [DATA_W-1:0]   pix_data_i,
  output logic                pix_ready_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic [9*DATA_W-1:0] win_o,
  output logic [ROW_W-1:0]    win_row_o,
  output logic [COL_W-1:0]    win_col_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);
  localparam logic [ROW_W-1:0] PEN_ROW  = ROW_W'(IMG_ROWS - 2);

  typedef enum logic [1:0] {StIdle, StFill, StEmit, StLast} state_e;

  state_e r_state, w_state_d;

  logic [COL_W-1:0]    r_wr_col;
  logic [ROW_W-1:0]    r_wr_row;
  logic [1:0]          r_wr_line;
  logic [ROW_W-1:0]    r_ctr_row;
  logic [1:0]          r_ctr_line;
  logic [COL_W-1:0]    r_rd_col;
  logic                r_rd_pend;   // windows of the centre row still to be loaded
  logic [9*DATA_W-1:0] r_win;
  logic                r_win_valid;
  logic [ROW_W-1:0]    r_win_row;
  logic [COL_W-1:0]    r_win_col;
  logic                r_frame_done;

  logic [DATA_W-1:0] r_line_mem [3][IMG_COLS];

  logic                w_pix_acc, w_row_end, w_win_acc, w_emit, w_load, w_row_done, w_to_last;
  logic [9*DATA_W-1:0] w_win;
  logic [1:0]          w_line [3];
  logic [COL_W-1:0]    w_col [3];
  logic [2:0]          w_row_ok, w_col_ok;

  assign w_pix_acc  = (r_state == StFill) && pix_valid_i;
  assign w_row_end  = w_pix_acc && (r_wr_col == LAST_COL);
  assign w_win_acc  = r_win_valid && win_ready_i;
  assign w_emit     = (r_state == StEmit) || (r_state == StLast);
  // Output register is refilled when empty or being drained this cycle.
  assign w_load     = w_emit && r_rd_pend && (!r_win_valid || win_ready_i);
  // The final column is only in the output register once nothing is pending.
  assign w_row_done = w_win_acc && !r_rd_pend && (r_win_col == LAST_COL);
  assign w_to_last  = (r_state == StEmit) && w_row_done && (r_ctr_row == PEN_ROW);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (start_i) w_state_d = StFill;
      StFill: if (w_row_end && (r_wr_row != '0)) w_state_d = StEmit;
      StEmit: if (w_row_done) w_state_d = w_to_last ? StLast : StFill;
      StLast: if (w_row_done) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    pix_ready_o = (r_state == StFill);
    busy_o      = (r_state != StIdle);
  end

  // Line buffers: no reset, padding is produced by masking on read.
  always_ff @(posedge clk) begin
    if (w_pix_acc) r_line_mem[r_wr_line][r_wr_col] <= pix_data_i;
  end

  // Window assembly for centre (r_ctr_row, r_rd_col)
  always_comb begin
    w_line[0] = (r_ctr_line == 2'd0) ? 2'd2 : r_ctr_line - 2'd1;
    w_line[1] = r_ctr_line;
    w_line[2] = (r_ctr_line == 2'd2) ? 2'd0 : r_ctr_line + 2'd1;
    // Clamp neighbour columns so reads stay in range; the values are masked anyway.
    w_col[0]  = (r_rd_col == '0) ? '0 : r_rd_col - COL_W'(1);
    w_col[1]  = r_rd_col;
    w_col[2]  = (r_rd_col == LAST_COL) ? r_rd_col : r_rd_col + COL_W'(1);
    w_row_ok  = {(r_ctr_row != LAST_ROW), 1'b1, (r_ctr_row != '0)};
    w_col_ok  = {(r_rd_col != LAST_COL), 1'b1, (r_rd_col != '0)};
    w_win     = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (w_row_ok[i] && w_col_ok[j]) begin
          w_win[(3*i+j)*DATA_W +: DATA_W] = r_line_mem[w_line[i]][w_col[j]];
        end
      end
    end
  end

  // Counters and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_wr_line    <= '0;
      r_ctr_row    <= '0;
      r_ctr_line   <= '0;
      r_rd_col     <= '0;
      r_rd_pend    <= 1'b0;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == StLast) && w_row_done;
      if ((r_state == StIdle) && start_i) begin
        r_wr_col  <= '0;
        r_wr_row  <= '0;
        r_wr_line <= '0;
      end
      if (w_pix_acc) begin
        if (w_row_end) begin
          r_wr_col  <= '0;
          r_wr_row  <= r_wr_row + ROW_W'(1);
          r_wr_line <= (r_wr_line == 2'd2) ? 2'd0 : r_wr_line + 2'd1;
        end else begin
          r_wr_col <= r_wr_col + COL_W'(1);
        end
      end
      // Completing row w makes row w-1 emittable; its line precedes w's line.
      if (w_row_end && (r_wr_row != '0)) begin
        r_ctr_row  <= r_wr_row - ROW_W'(1);
        r_ctr_line <= (r_wr_line == 2'd0) ? 2'd2 : r_wr_line - 2'd1;
        r_rd_col   <= '0;
        r_rd_pend  <= 1'b1;
      end
      if (w_to_last) begin
        r_ctr_row  <= r_ctr_row + ROW_W'(1);
        r_ctr_line <= (r_ctr_line == 2'd2) ? 2'd0 : r_ctr_line + 2'd1;
        r_rd_col   <= '0;
        r_rd_pend  <= 1'b1;
      end
      if (w_load) begin
        r_win       <= w_win;
        r_win_valid <= 1'b1;
        r_win_row   <= r_ctr_row;
        r_win_col   <= r_rd_col;
        if (r_rd_col == LAST_COL) r_rd_pend <= 1'b0;
        else                      r_rd_col  <= r_rd_col + COL_W'(1);
      end else if (w_win_acc) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_o        = r_win;
  assign win_valid_o  = r_win_valid;
  assign win_row_o    = r_win_row;
  assign win_col_o    = r_win_col;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: a 4x3 instance for the functional cases and a
// 540x4 instance for column wrap and back-to-back frames. Outputs are sampled and
// inputs driven on the falling clock edge.
module tb_line_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b, pix_valid, win_ready;
  logic [7:0]  pix_data;

  logic        a_pix_ready, a_win_valid, a_busy, a_frame_done;
  logic [71:0] a_win;
  logic [1:0]  a_row, a_col;
  logic        b_pix_ready, b_win_valid, b_busy, b_frame_done;
  logic [71:0] b_win;
  logic [2:0]  b_row;
  logic [9:0]  b_col;

  line_window_gen #(
    .DATA_W(8), .IMG_COLS(4), .IMG_ROWS(3), .COL_W(2), .ROW_W(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .pix_valid_i(pix_valid),
    .pix_data_i(pix_data), .pix_ready_o(a_pix_ready), .win_valid_o(a_win_valid),
    .win_ready_i(win_ready), .win_o(a_win), .win_row_o(a_row), .win_col_o(a_col),
    .busy_o(a_busy), .frame_done_o(a_frame_done)
  );

  line_window_gen #(
    .DATA_W(8), .IMG_COLS(540), .IMG_ROWS(4), .COL_W(10), .ROW_W(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .pix_valid_i(pix_valid),
    .pix_data_i(pix_data), .pix_ready_o(b_pix_ready), .win_valid_o(b_win_valid),
    .win_ready_i(win_ready), .win_o(b_win), .win_row_o(b_row), .win_col_o(b_col),
    .busy_o(b_busy), .frame_done_o(b_frame_done)
  );

  // Selected DUT view
  bit          sel;
  logic        m_pix_ready, m_win_valid, m_busy, m_frame_done;
  logic [71:0] m_win;
  int          m_row, m_col;
  assign m_pix_ready  = sel ? b_pix_ready  : a_pix_ready;
  assign m_win_valid  = sel ? b_win_valid  : a_win_valid;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_win        = sel ? b_win        : a_win;
  assign m_row        = sel ? int'(b_row)  : int'(a_row);
  assign m_col        = sel ? int'(b_col)  : int'(a_col);

  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_total = 0;
  int          win_cnt, pix_cnt, fd_cnt;
  logic [71:0] cap [2160];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int ofs);
    return 8'(16 * r + c + 1 + ofs);
  endfunction

  function automatic logic [71:0] exp_win(input int r, input int c, input int rows,
                                          input int cols, input int ofs);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr, cc;
        rr = r - 1 + i;
        cc = c - 1 + j;
        if (rr >= 0 && rr < rows && cc >= 0 && cc < cols) w[(3*i+j)*8 +: 8] = pix(rr, cc, ofs);
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] pack9(input int e0, input int e1, input int e2,
                                        input int e3, input int e4, input int e5,
                                        input int e6, input int e7, input int e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // One frame on the selected DUT. bp_k: window index held for bp_len cycles;
  // abort_k: stop once that many windows have been accepted (no end checks).
  task automatic run_frame(input int cols, input int rows, input int ofs, input bit gap,
                           input int bp_k, input int bp_len, input bit start_in_fill,
                           input int abort_k);
    int k, p, cyc, hold, total, budget;
    bit finished;
    k = 0; p = 0; cyc = 0; hold = 0; finished = 0;
    total  = cols * rows;
    budget = 4 * total + 100;
    fd_cnt = 0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    while (!finished && cyc < budget) begin
      pix_valid = (p < total) && (!gap || (cyc % 2 == 0));
      pix_data  = pix(p / cols, p % cols, ofs);
      set_start(start_in_fill && (p == 2) && m_pix_ready);
      if (pix_valid && m_pix_ready) p++;
      if (m_win_valid) begin
        chk("pix_ready_while_emit", m_pix_ready, 0);
        if (k == bp_k && hold < bp_len) begin
          win_ready = 1'b0;
          chk("bp_hold_win", m_win, exp_win(bp_k / cols, bp_k % cols, rows, cols, ofs));
          chk("bp_hold_col", m_col, bp_k % cols);
          hold++;
        end else begin
          win_ready = 1'b1;
          chk($sformatf("win_%0d", k), m_win, exp_win(k / cols, k % cols, rows, cols, ofs));
          chk($sformatf("row_%0d", k), m_row, k / cols);
          chk($sformatf("col_%0d", k), m_col, k % cols);
          if (k < 2160) cap[k] = m_win;
          k++;
        end
      end else begin
        win_ready = 1'b1;
      end
      if (m_frame_done) begin
        fd_cnt++;
        fd_total++;
        chk("busy_at_done", m_busy, 0);
        finished = 1;
      end
      if (abort_k >= 0 && k == abort_k) finished = 1;
      cyc++;
      @(negedge clk);
    end
    set_start(1'b0);
    pix_valid = 1'b0;
    win_cnt = k;
    pix_cnt = p;
    if (abort_k < 0) begin
      chk("frame_finished", finished, 1);
      chk("window_count", k, total);
      chk("pixel_count", p, total);
      chk("frame_done_count", fd_cnt, 1);
      chk("frame_done_pulse_width", m_frame_done, 0);
      chk("busy_idle", m_busy, 0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pix_ready"}, m_pix_ready, 0);
    chk({tag, "_win_valid"}, m_win_valid, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_frame_done"}, m_frame_done, 0);
    chk({tag, "_win"}, m_win, 0);
    chk({tag, "_row_col"}, {m_row, m_col}, 0);
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    pix_valid = 1'b0; win_ready = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset_a");
    sel = 1;
    #0 chk_reset_state("reset_b");
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full frame, ready always high
    run_frame(4, 3, 0, 0, -1, 0, 0, -1);
    chk("t1_win_0_0", cap[0],  pack9(0, 0, 0, 0, 1, 2, 0, 17, 18));
    chk("t1_win_1_1", cap[5],  pack9(1, 2, 3, 17, 18, 19, 33, 34, 35));
    chk("t1_win_2_3", cap[11], pack9(19, 20, 0, 35, 36, 0, 0, 0, 0));

    // 2: input gaps
    run_frame(4, 3, 0, 1, -1, 0, 0, -1);
    chk("t2_win_1_1", cap[5], pack9(1, 2, 3, 17, 18, 19, 33, 34, 35));

    // 3: backpressure at window (1,2)
    run_frame(4, 3, 0, 0, 6, 5, 0, -1);
    chk("t3_win_1_2", cap[6], pack9(2, 3, 4, 18, 19, 20, 34, 35, 36));

    // 4: reset while emitting centre row 1, then a frame with different data
    run_frame(4, 3, 0, 0, -1, 0, 0, 5);
    chk("t4_aborted_in_row1", win_cnt, 5);
    rst_n = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    chk_reset_state("t4_reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(4, 3, 100, 0, -1, 0, 0, -1);
    chk("t4_win_0_0", cap[0],  pack9(0, 0, 0, 0, 101, 102, 0, 117, 118));
    chk("t4_win_2_3", cap[11], pack9(119, 120, 0, 135, 136, 0, 0, 0, 0));

    // 5: start pulsed during FILL (pix_valid stays high through EMIT as well)
    run_frame(4, 3, 0, 0, -1, 0, 1, -1);
    chk("t5_win_2_3", cap[11], pack9(19, 20, 0, 35, 36, 0, 0, 0, 0));

    // 6: two back-to-back 540x4 frames
    sel = 1;
    run_frame(540, 4, 0, 0, -1, 0, 0, -1);
    chk("t6_win_1_539", cap[1079], pack9(27, 28, 0, 43, 44, 0, 59, 60, 0));
    chk("t6_win_2_0",   cap[1080], pack9(0, 17, 18, 0, 33, 34, 0, 49, 50));
    run_frame(540, 4, 0, 0, -1, 0, 0, -1);
    chk("t6_win_count_f2", win_cnt, 2160);
    chk("t6_frame_done_total", fd_total, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
